// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP slice sequencer.
// Contents:
//   state_t             - sequencer FSM states
//   OPM_*               - OPMODE field positions and select codes for the slice
//   opmode_enc()        - assembles an OPMODE word from its fields
//   MAC_OPMODE_DEFAULT  - X=M, Z=P, add, no pre-adder, carry-in 0 (8'h09)
//   PIPE_DEPTH          - valid-pipe depth matching the slice A/B -> M -> P registers
package dsp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // OPMODE layout: [1:0] X select, [3:2] Z select, then single-bit controls.
   localparam int OPM_X_LSB       = 0;
   localparam int OPM_Z_LSB       = 2;
   localparam int OPM_PREADD_BIT  = 4;
   localparam int OPM_CARRYIN_BIT = 5;
   localparam int OPM_PRESUB_BIT  = 6;
   localparam int OPM_POSTSUB_BIT = 7;

   localparam logic [1:0] OPM_X_M = 2'b01;
   localparam logic [1:0] OPM_Z_P = 2'b10;

   localparam int PIPE_DEPTH = 3;

   function automatic logic [7:0] opmode_enc(
      input logic [1:0] x_sel,
      input logic [1:0] z_sel,
      input logic       pre_en,
      input logic       carry_in,
      input logic       pre_sub,
      input logic       post_sub
   );
      logic [7:0] word;
      word                      = '0;
      word[OPM_X_LSB +: 2]      = x_sel;
      word[OPM_Z_LSB +: 2]      = z_sel;
      word[OPM_PREADD_BIT]      = pre_en;
      word[OPM_CARRYIN_BIT]     = carry_in;
      word[OPM_PRESUB_BIT]      = pre_sub;
      word[OPM_POSTSUB_BIT]     = post_sub;
      return word;
   endfunction

   localparam logic [7:0] MAC_OPMODE_DEFAULT =
      opmode_enc(OPM_X_M, OPM_Z_P, 1'b0, 1'b0, 1'b0, 1'b0);

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1-style slice as an unsigned multiply-accumulate engine.
// A job of LEN operand pairs is streamed in; the 48-bit accumulated P and a
// sticky overflow flag are returned over a result handshake.
// Ports:
//   CLK, RST_N               - clock (shared with the slice), async active-low reset
//   START, LEN, ABORT, BUSY  - job control
//   OP_A, OP_B, OP_VALID, OP_READY        - operand stream
//   RES_P, RES_OVF, RES_VALID, RES_READY  - result handshake
//   DSP_*                    - slice operand, OPMODE, clock-enable and sync-reset pins
//   DSP_P, DSP_CARRYOUT      - slice outputs
module dsp_mac_sequencer
   import dsp_ctrl_pkg::*;
#(
   parameter int unsigned LEN_W      = 16,
   parameter logic [7:0]  MAC_OPMODE = MAC_OPMODE_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic             ABORT,
   output logic             BUSY,
   input  logic [17:0]      OP_A,
   input  logic [17:0]      OP_B,
   input  logic             OP_VALID,
   output logic             OP_READY,
   output logic [47:0]      RES_P,
   output logic             RES_OVF,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [17:0]      DSP_A,
   output logic [17:0]      DSP_B,
   output logic [7:0]       DSP_OPMODE,
   output logic             DSP_CEOPMODE,
   output logic             DSP_CEA,
   output logic             DSP_CEB,
   output logic             DSP_CEM,
   output logic             DSP_CEP,
   output logic             DSP_CECARRYIN,
   output logic             DSP_RSTAB,
   output logic             DSP_RSTM,
   output logic             DSP_RSTP,
   output logic             DSP_RSTCARRYIN,
   input  logic [47:0]      DSP_P,
   input  logic             DSP_CARRYOUT
);

   state_t                state_reg, state_next;
   logic [LEN_W-1:0]      len_reg, cnt_reg, cnt_plus;
   logic [PIPE_DEPTH-1:0] pipe_reg, pipe_next;
   logic                  ovf_reg;
   logic [47:0]           res_p_reg;
   logic                  res_ovf_reg;
   logic                  srst_pulse_reg;

   logic feed, accept, load_rst, abort_taken, start_job, zero_job, finish;
   logic carry_hit;

   assign cnt_plus  = cnt_reg + 1'b1;
   // CARRYOUT is only meaningful in the cycle after P absorbed a product.
   assign carry_hit = pipe_reg[PIPE_DEPTH-1] & DSP_CARRYOUT;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      feed        = 1'b0;
      accept      = 1'b0;
      load_rst    = 1'b0;
      abort_taken = 1'b0;
      start_job   = 1'b0;
      zero_job    = 1'b0;
      finish      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  start_job  = 1'b1;
                  state_next = ST_LOAD;
               end else begin
                  zero_job   = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            // Clear M/P/carry and load OPMODE before the first beat arrives.
            load_rst = 1'b1;
            if (ABORT) begin
               abort_taken = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               state_next = ST_FEED;
            end
         end
         ST_FEED: begin
            feed   = 1'b1;
            accept = OP_VALID;
            if (ABORT) begin
               abort_taken = 1'b1;
               state_next  = ST_IDLE;
            end else if (accept && (cnt_plus == len_reg)) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (ABORT) begin
               abort_taken = 1'b1;
               state_next  = ST_IDLE;
            end else if (pipe_reg[PIPE_DEPTH-2:0] == '0) begin
               // Last stage is being consumed now, so DSP_P is final.
               finish     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (RES_READY) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Valid pipe mirrors the slice registers: s1 = A/B loaded, s2 = M loaded,
   // s3 = P loaded. Abort empties it so no stale product reaches P.
   genvar gi;
   generate
      for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            assign pipe_next[gi] = accept & ~abort_taken;
         end else begin : g_tail
            assign pipe_next[gi] = pipe_reg[gi-1] & ~abort_taken;
         end
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         len_reg        <= '0;
         cnt_reg        <= '0;
         pipe_reg       <= '0;
         ovf_reg        <= 1'b0;
         res_p_reg      <= '0;
         res_ovf_reg    <= 1'b0;
         // Held high through reset so the slice is cleared on the first edge after release.
         srst_pulse_reg <= 1'b1;
      end else begin
         pipe_reg       <= pipe_next;
         srst_pulse_reg <= abort_taken;
         if (start_job) begin
            len_reg <= LEN;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
         end else begin
            if (accept)    cnt_reg <= cnt_plus;
            if (carry_hit) ovf_reg <= 1'b1;
         end
         if (zero_job) begin
            res_p_reg   <= '0;
            res_ovf_reg <= 1'b0;
         end else if (finish) begin
            res_p_reg   <= DSP_P;
            res_ovf_reg <= ovf_reg | carry_hit;
         end
      end
   end

   assign BUSY           = (state_reg != ST_IDLE);
   assign OP_READY       = feed;
   assign RES_VALID      = (state_reg == ST_DONE);
   assign RES_P          = res_p_reg;
   assign RES_OVF        = res_ovf_reg;

   assign DSP_A          = feed ? OP_A : '0;
   assign DSP_B          = feed ? OP_B : '0;
   assign DSP_CEA        = accept;
   assign DSP_CEB        = accept;
   assign DSP_CEM        = pipe_reg[0];
   assign DSP_CEP        = pipe_reg[1];
   assign DSP_CECARRYIN  = pipe_reg[1];
   assign DSP_OPMODE     = load_rst ? MAC_OPMODE : 8'h00;
   assign DSP_CEOPMODE   = load_rst;
   assign DSP_RSTAB      = srst_pulse_reg;
   assign DSP_RSTM       = srst_pulse_reg | load_rst;
   assign DSP_RSTP       = srst_pulse_reg | load_rst;
   assign DSP_RSTCARRYIN = srst_pulse_reg | load_rst;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model
// (A/B -> M -> P registers, registered carry-out, registered OPMODE).
module tb_dsp_mac_sequencer;

   localparam int LEN_W = 16;

   logic             CLK       = 1'b0;
   logic             RST_N     = 1'b0;
   logic             START     = 1'b0;
   logic [LEN_W-1:0] LEN       = '0;
   logic             ABORT     = 1'b0;
   logic             BUSY;
   logic [17:0]      OP_A      = '0;
   logic [17:0]      OP_B      = '0;
   logic             OP_VALID  = 1'b0;
   logic             OP_READY;
   logic [47:0]      RES_P;
   logic             RES_OVF;
   logic             RES_VALID;
   logic             RES_READY = 1'b1;
   logic [17:0]      DSP_A, DSP_B;
   logic [7:0]       DSP_OPMODE;
   logic             DSP_CEOPMODE, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CECARRYIN;
   logic             DSP_RSTAB, DSP_RSTM, DSP_RSTP, DSP_RSTCARRYIN;
   logic [47:0]      DSP_P;
   logic             DSP_CARRYOUT;

   dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .ABORT(ABORT), .BUSY(BUSY),
      .OP_A(OP_A), .OP_B(OP_B), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
      .RES_P(RES_P), .RES_OVF(RES_OVF), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CEOPMODE(DSP_CEOPMODE),
      .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
      .DSP_CECARRYIN(DSP_CECARRYIN), .DSP_RSTAB(DSP_RSTAB), .DSP_RSTM(DSP_RSTM),
      .DSP_RSTP(DSP_RSTP), .DSP_RSTCARRYIN(DSP_RSTCARRYIN),
      .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- slice model ----------------
   logic [17:0] a_r = '0, b_r = '0;
   logic [35:0] m_r = '0;
   logic [7:0]  opm_r = '0;
   logic [47:0] p_r = '0;
   logic        co_r = 1'b0;
   logic [47:0] x_mux, z_mux;
   logic [48:0] post_sum;

   always_comb begin
      x_mux    = (opm_r[1:0] == 2'b01) ? {12'b0, m_r} : 48'b0;
      z_mux    = (opm_r[3:2] == 2'b10) ? p_r : 48'b0;
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'b0, opm_r[5]};
   end

   always @(posedge CLK) begin
      if (DSP_RSTAB) begin
         a_r <= '0;
         b_r <= '0;
      end else begin
         if (DSP_CEA) a_r <= DSP_A;
         if (DSP_CEB) b_r <= DSP_B;
      end
      if (DSP_RSTM) m_r <= '0;
      else if (DSP_CEM) m_r <= {18'b0, a_r} * {18'b0, b_r};
      if (DSP_CEOPMODE) opm_r <= DSP_OPMODE;
      if (DSP_RSTP) p_r <= '0;
      else if (DSP_CEP) p_r <= post_sum[47:0];
      if (DSP_RSTCARRYIN) co_r <= 1'b0;
      else if (DSP_CECARRYIN) co_r <= post_sum[48];
   end

   assign DSP_P        = p_r;
   assign DSP_CARRYOUT = co_r;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [47:0] p;
      logic        ovf;
   } sb_item_t;

   sb_item_t    sb_q[$];
   logic [17:0] a_q[$];
   logic [17:0] b_q[$];

   int cep_total = 0;
   always @(negedge CLK) begin
      if (DSP_CEP) cep_total <= cep_total + 1;
   end

   // Scoreboard: every completed handshake must match the oldest expectation.
   always @(negedge CLK) begin
      if (RST_N && RES_VALID && RES_READY) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 64'(RES_P), 64'hDEAD_0000_0000);
         end else begin
            chk("res_p", 64'(RES_P), 64'(sb_q[0].p));
            chk("res_ovf", 64'(RES_OVF), 64'(sb_q[0].ovf));
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic set_ops(input int n, input logic [17:0] a, input logic [17:0] b);
      a_q.delete();
      b_q.delete();
      for (int i = 0; i < n; i++) begin
         a_q.push_back(a);
         b_q.push_back(b);
      end
   endtask

   // Runs one job from posedge+1 and returns at posedge+1 of the cycle after the handshake.
   task automatic run_job(input int len, input bit gaps, input int exp_cycle);
      sb_item_t    item;
      logic [63:0] acc;
      int          idx, k, guard, c0, t_first, t_last, cep0;
      bit          got_beat;
      acc = '0;
      for (int i = 0; i < len; i++) acc += 64'(a_q[i]) * 64'(b_q[i]);
      item.p   = acc[47:0];
      item.ovf = (acc >= 64'h1_0000_0000_0000);
      sb_q.push_back(item);
      cep0    = cep_total;
      idx     = 0;
      k       = 0;
      guard   = 0;
      t_first = -1;
      t_last  = -1;
      START   = 1'b1;
      LEN     = len[LEN_W-1:0];
      c0      = cyc;
      @(posedge CLK); #1;
      START = 1'b0;
      LEN   = '0;
      while (idx < len && guard < 3 * len + 20) begin
         OP_VALID = gaps ? (k % 2 == 1) : 1'b1;
         OP_A     = a_q[idx];
         OP_B     = b_q[idx];
         @(negedge CLK);
         if (k == 0) begin
            chk("load_busy", 64'(BUSY), 64'd1);
            chk("load_opmode", 64'(DSP_OPMODE), 64'h09);
            chk("load_ceopmode", 64'(DSP_CEOPMODE), 64'd1);
            chk("load_rstp", 64'(DSP_RSTP), 64'd1);
         end
         got_beat = OP_VALID && OP_READY;
         if (got_beat) begin
            if (t_first < 0) t_first = cyc;
            t_last = cyc;
         end
         @(posedge CLK); #1;
         if (got_beat) idx++;
         k++;
         guard++;
      end
      OP_VALID = 1'b0;
      chk("beats_accepted", 64'(idx), 64'(len));
      if (!gaps) chk("first_beat_cycle", 64'(t_first - c0), 64'd2);
      @(negedge CLK);
      chk("ready_drop", 64'(OP_READY), 64'd0);
      guard = 0;
      while (!RES_VALID && guard < 64) begin
         @(negedge CLK);
         guard++;
      end
      chk("res_valid_seen", 64'(RES_VALID), 64'd1);
      chk("res_latency", 64'(cyc - t_last), 64'd4);
      if (exp_cycle >= 0) chk("res_cycle", 64'(cyc - c0), 64'(exp_cycle));
      chk("cep_pulses", 64'(cep_total - cep0), 64'(len));
      @(posedge CLK); #1;
   endtask

   initial begin
      int c0;

      // ---- reset state ----
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_res_valid", 64'(RES_VALID), 64'd0);
      chk("rst_res_p", 64'(RES_P), 64'd0);
      chk("rst_op_ready", 64'(OP_READY), 64'd0);
      chk("rst_dsp_rstab", 64'(DSP_RSTAB), 64'd1);
      chk("rst_dsp_opmode", 64'(DSP_OPMODE), 64'd0);
      chk("rst_dsp_cep", 64'(DSP_CEP), 64'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("post_rst_rstp_high", 64'(DSP_RSTP), 64'd1);
      @(negedge CLK);
      chk("post_rst_rstp_low", 64'(DSP_RSTP), 64'd0);
      @(posedge CLK); #1;

      // ---- LEN=3, held valid ----
      a_q.delete(); b_q.delete();
      a_q.push_back(18'd3); b_q.push_back(18'd4);
      a_q.push_back(18'd5); b_q.push_back(18'd6);
      a_q.push_back(18'd7); b_q.push_back(18'd8);
      run_job(3, 1'b0, 8);

      // ---- same job with stalls, started back-to-back ----
      run_job(3, 1'b1, -1);

      // ---- LEN=4097 max operands: wraps past 2^48 ----
      set_ops(4097, 18'h3FFFF, 18'h3FFFF);
      run_job(4097, 1'b0, -1);

      // ---- LEN=0 with result back-pressure ----
      sb_q.push_back('{p: 48'd0, ovf: 1'b0});
      RES_READY = 1'b0;
      START     = 1'b1;
      LEN       = '0;
      c0        = cyc;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (i == 0) chk("zero_res_cycle", 64'(cyc - c0), 64'd1);
         chk("zero_res_valid", 64'(RES_VALID), 64'd1);
         chk("zero_res_p_stable", 64'(RES_P), 64'd0);
         chk("zero_busy", 64'(BUSY), 64'd1);
      end
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      @(negedge CLK);
      @(posedge CLK); #1;

      // ---- abort after 2 beats of LEN=5 ----
      START = 1'b1;
      LEN   = 16'd5;
      @(posedge CLK); #1;
      START    = 1'b0;
      LEN      = '0;
      OP_VALID = 1'b1;
      OP_A     = 18'd11;
      OP_B     = 18'd13;
      repeat (3) @(posedge CLK);
      #1;
      OP_VALID = 1'b0;
      ABORT    = 1'b1;
      @(posedge CLK); #1;
      ABORT = 1'b0;
      @(negedge CLK);
      chk("abort_busy", 64'(BUSY), 64'd0);
      chk("abort_rstab", 64'(DSP_RSTAB), 64'd1);
      chk("abort_rstp", 64'(DSP_RSTP), 64'd1);
      chk("abort_pipe_clear", 64'(DSP_CEP), 64'd0);
      @(posedge CLK); #1;
      set_ops(1, 18'd2, 18'd9);
      run_job(1, 1'b0, 6);

      // ---- async reset in the middle of FEED ----
      START = 1'b1;
      LEN   = 16'd3;
      @(posedge CLK); #1;
      START    = 1'b0;
      LEN      = '0;
      OP_VALID = 1'b1;
      OP_A     = 18'd100;
      OP_B     = 18'd200;
      repeat (3) @(posedge CLK);
      #1;
      chk("pre_reset_ready", 64'(OP_READY), 64'd1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(BUSY), 64'd0);
      chk("mid_rst_op_ready", 64'(OP_READY), 64'd0);
      chk("mid_rst_cea", 64'(DSP_CEA), 64'd0);
      chk("mid_rst_cem", 64'(DSP_CEM), 64'd0);
      chk("mid_rst_rstp", 64'(DSP_RSTP), 64'd1);
      chk("mid_rst_res_p", 64'(RES_P), 64'd0);
      OP_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rel_rstp_high", 64'(DSP_RSTP), 64'd1);
      @(negedge CLK);
      chk("rel_rstp_low", 64'(DSP_RSTP), 64'd0);
      @(posedge CLK); #1;
      set_ops(1, 18'd1, 18'd1);
      run_job(1, 1'b0, 6);

      repeat (4) @(posedge CLK);
      #1;
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
